// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing defaults, pixel type and total-length helper
// Contents:
//   DEF_* localparams : 640x480@60 timing set used as the top-level defaults
//   rgb222_t          : 2-bit-per-channel packed colour, r in the MSBs
//   vga_total()       : active + front porch + sync + back porch for one axis
package vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef struct packed {
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
    } rgb222_t;

    function automatic int vga_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one raster axis counter (horizontal or vertical)
// Counts 0..TOTAL-1 on each inc_i and wraps to 0.
// Ports:
//   clk_i, rst_i : clock, asynchronous active-high reset
//   inc_i        : advance the count by one
//   cnt_o        : current position on the axis
//   wrap_o       : count is at TOTAL-1 (terminal count, not qualified by inc_i)
//   active_o     : count lies in the visible region
//   sync_o       : count lies in the sync pulse region
module vga_axis_counter import vga_pkg::*; #(
    parameter int ACTIVE = 640,
    parameter int FP     = 16,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter int W      = $clog2(vga_total(ACTIVE, FP, SYNC, BP))
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o,
    output logic         wrap_o,
    output logic         active_o,
    output logic         sync_o
);

    localparam int TOTAL = vga_total(ACTIVE, FP, SYNC, BP);

    localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_END    = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_END   = W'(ACTIVE + FP + SYNC);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o    = cnt_q;
    assign wrap_o   = (cnt_q == LAST);
    assign active_o = (cnt_q < ACT_END);
    assign sync_o   = (cnt_q >= SYNC_START) && (cnt_q < SYNC_END);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster timing generator and registered colour/sync output stage
// Optional feature macro: VGA_TEST_PATTERN_EN (adds tp_en_i and an 8-bar colour test pattern).
// Ports:
//   clk_i, rst_i       : pixel clock, asynchronous active-high reset
//   en_i               : advance raster; low freezes counters and output stage
//   x_o, y_o, de_o     : stage-0 pixel request (current coordinate and display-enable)
//   pix_i              : {rr,gg,bb} for the coordinate currently on x_o/y_o
//   tp_en_i            : test-pattern select (VGA_TEST_PATTERN_EN builds only)
//   r_o, g_o, b_o      : registered colour, blanked outside the active area
//   hs_o, vs_o         : registered sync levels, aligned with the colour
//   next_vertical_o    : 1-clock strobe while the output shows the last clock of a line
//   next_frame_o       : 1-clock strobe while the output shows the last clock of a frame
module vga_timing_gen import vga_pkg::*; #(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    localparam int XW      = $clog2(vga_total(H_ACTIVE, H_FP, H_SYNC, H_BP)),
    localparam int YW      = $clog2(vga_total(V_ACTIVE, V_FP, V_SYNC, V_BP))
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          en_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          de_o,
    input  logic [5:0]    pix_i,
`ifdef VGA_TEST_PATTERN_EN
    input  logic          tp_en_i,
`endif
    output logic [1:0]    r_o,
    output logic [1:0]    g_o,
    output logic [1:0]    b_o,
    output logic          hs_o,
    output logic          vs_o,
    output logic          next_vertical_o,
    output logic          next_frame_o
);

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1) begin : g_bad_h
        $error("vga_timing_gen: every horizontal timing parameter must be >= 1");
    end
    if (V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_v
        $error("vga_timing_gen: every vertical timing parameter must be >= 1");
    end
    if ((HS_POL != 0 && HS_POL != 1) || (VS_POL != 0 && VS_POL != 1)) begin : g_bad_pol
        $error("vga_timing_gen: HS_POL and VS_POL must each be 0 or 1");
    end

    localparam logic HS_ACT = (HS_POL != 0);
    localparam logic VS_ACT = (VS_POL != 0);

    logic [XW-1:0] h_cnt;
    logic [YW-1:0] v_cnt;
    logic          h_last, h_act, h_sync;
    logic          v_last, v_act, v_sync;
    logic          de;

    vga_axis_counter #(
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP),
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .W      (XW)
    ) u_h_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .inc_i    (en_i),
        .cnt_o    (h_cnt),
        .wrap_o   (h_last),
        .active_o (h_act),
        .sync_o   (h_sync)
    );

    // The line counter only steps on the enabled clock that wraps h.
    vga_axis_counter #(
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP),
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .W      (YW)
    ) u_v_cnt (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .inc_i    (en_i & h_last),
        .cnt_o    (v_cnt),
        .wrap_o   (v_last),
        .active_o (v_act),
        .sync_o   (v_sync)
    );

    assign de   = h_act & v_act;
    assign x_o  = h_cnt;
    assign y_o  = v_cnt;
    assign de_o = de;

    rgb222_t pix_sel;

`ifdef VGA_TEST_PATTERN_EN
    // Bar index only matters inside the active area, where it is always < 8.
    logic [2:0] bar_k;
    assign bar_k   = 3'({h_cnt, 3'b000} / (XW + 3)'(H_ACTIVE));
    assign pix_sel = tp_en_i ? rgb222_t'({{2{bar_k[2]}}, {2{bar_k[1]}}, {2{bar_k[0]}}})
                             : rgb222_t'(pix_i);
`else
    assign pix_sel = rgb222_t'(pix_i);
`endif

    rgb222_t rgb_q, rgb_d;
    logic    hs_q, hs_d;
    logic    vs_q, vs_d;
    logic    nv_q, nv_d;
    logic    nf_q, nf_d;

    // Strobes clear on a frozen clock so a held stage cannot re-pulse.
    always_comb begin
        rgb_d = rgb_q;
        hs_d  = hs_q;
        vs_d  = vs_q;
        nv_d  = 1'b0;
        nf_d  = 1'b0;
        if (en_i) begin
            rgb_d = de ? pix_sel : rgb222_t'(6'h00);
            hs_d  = h_sync ? HS_ACT : ~HS_ACT;
            vs_d  = v_sync ? VS_ACT : ~VS_ACT;
            nv_d  = h_last;
            nf_d  = h_last & v_last;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rgb_q <= rgb222_t'(6'h00);
            hs_q  <= ~HS_ACT;
            vs_q  <= ~VS_ACT;
            nv_q  <= 1'b0;
            nf_q  <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            nv_q  <= nv_d;
            nf_q  <= nf_d;
        end
    end

    assign r_o             = rgb_q.r;
    assign g_o             = rgb_q.g;
    assign b_o             = rgb_q.b;
    assign hs_o            = hs_q;
    assign vs_o            = vs_q;
    assign next_vertical_o = nv_q;
    assign next_frame_o    = nf_q;

endmodule
